// File: rtl/kuznechik_arbiter.sv
// Two-client front end for a Kuznechik block-cipher core.
// Clients post 128-bit plaintext blocks. One block at a time is handed to the
// core. The ciphertext is returned to the requester and held until that client
// acknowledges it. The owner pointer also drives round-robin arbitration when
// RR_EN is set; otherwise client 0 has fixed priority.
module kuznechik_arbiter #(
  parameter int RR_EN = 1
) (
  input  logic         clk_i,
  input  logic         resetn_i,

  input  logic         c0_req_i,
  input  logic [127:0] c0_data_i,
  output logic         c0_gnt_o,
  output logic         c0_valid_o,
  output logic [127:0] c0_data_o,
  input  logic         c0_ack_i,

  input  logic         c1_req_i,
  input  logic [127:0] c1_data_i,
  output logic         c1_gnt_o,
  output logic         c1_valid_o,
  output logic [127:0] c1_data_o,
  input  logic         c1_ack_i,

  output logic         core_request_o,
  output logic [127:0] core_data_o,
  input  logic         core_busy_i,
  input  logic         core_valid_i,
  input  logic [127:0] core_data_i,
  output logic         core_ack_o,

  output logic         busy_o,
  output logic         owner_o,
  output logic [15:0]  done_cnt_o
);

  localparam int NCLI = 2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_DELIVER = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_next;

  // Per-client views of the request side, indexed by client number
  logic [NCLI-1:0] w_req;
  logic [NCLI-1:0] w_ack;
  logic [127:0]    w_cdata [NCLI];

  // Registered per-client handshake outputs and their next values
  logic [NCLI-1:0] r_gnt;
  logic [NCLI-1:0] w_gnt_next;
  logic [NCLI-1:0] r_valid;
  logic [NCLI-1:0] w_valid_next;

  logic            r_owner;
  logic            w_owner_next;
  logic            w_winner;

  // Single-cycle events that drive every state and output change
  logic            w_start;
  logic            w_take;
  logic            w_done;

  logic            r_core_request;
  logic            r_core_ack;
  logic            r_busy;
  logic            w_busy_next;
  logic [127:0]    r_core_data;
  logic [127:0]    w_core_data_next;
  logic [15:0]     r_done_cnt;
  logic [15:0]     w_done_cnt_next;

  assign w_req      = {c1_req_i, c0_req_i};
  assign w_ack      = {c1_ack_i, c0_ack_i};
  assign w_cdata[0] = c0_data_i;
  assign w_cdata[1] = c1_data_i;

  // Pick the winner among the current requesters. Round-robin hands a tie to
  // the client that was not served last time.
  always_comb begin
    w_winner = 1'b0;
    if (w_req == 2'b11) begin
      if (RR_EN != 0) begin
        w_winner = ~r_owner;
      end else begin
        w_winner = 1'b0;
      end
    end else if (w_req[1]) begin
      w_winner = 1'b1;
    end
  end

  // A grant needs an idle arbiter, a requester and a core that is not busy.
  assign w_start = (r_state == S_IDLE) && (|w_req) && !core_busy_i;

  // The core result is accepted in ISSUE as well as WAIT, so a zero-latency
  // core does not lose its answer.
  assign w_take  = ((r_state == S_ISSUE) || (r_state == S_WAIT)) && core_valid_i;

  // Only the owner's ack, while its valid is up, ends a delivery.
  assign w_done  = (r_state == S_DELIVER) && r_valid[r_owner] && w_ack[r_owner];

  // State register; reset abandons any block in flight
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_state_next = w_take ? S_DELIVER : S_WAIT;
      end
      S_WAIT: begin
        if (w_take) begin
          w_state_next = S_DELIVER;
        end
      end
      S_DELIVER: begin
        if (w_done) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Next values for the shared (non per-client) registered outputs
  always_comb begin
    w_busy_next      = (w_state_next != S_IDLE);
    w_owner_next     = r_owner;
    w_core_data_next = r_core_data;
    w_done_cnt_next  = r_done_cnt;
    if (w_start) begin
      w_owner_next     = w_winner;
      w_core_data_next = w_cdata[w_winner];
    end
    if (w_done) begin
      w_done_cnt_next = r_done_cnt + 16'd1;
    end
  end

  // Per-client grant, valid and ciphertext holding register
  genvar gi;
  generate
    for (gi = 0; gi < NCLI; gi++) begin : g_client
      logic         w_mine;
      logic [127:0] r_cout;

      assign w_mine          = (r_owner == 1'(gi));
      assign w_gnt_next[gi]  = w_start && (w_winner == 1'(gi));
      assign w_valid_next[gi] = (w_take && w_mine) ? 1'b1 :
                                (w_done && w_mine) ? 1'b0 : r_valid[gi];

      // Capture the core result for this client; hold it otherwise
      always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
          r_cout <= '0;
        end else if (w_take && w_mine) begin
          r_cout <= core_data_i;
        end
      end
    end
  endgenerate

  // Registered outputs; owner resets to 1 so client 0 wins the first tie
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_gnt          <= '0;
      r_valid        <= '0;
      r_core_request <= 1'b0;
      r_core_ack     <= 1'b0;
      r_busy         <= 1'b0;
      r_owner        <= 1'b1;
      r_core_data    <= '0;
      r_done_cnt     <= '0;
    end else begin
      r_gnt          <= w_gnt_next;
      r_valid        <= w_valid_next;
      r_core_request <= w_start;
      r_core_ack     <= w_take;
      r_busy         <= w_busy_next;
      r_owner        <= w_owner_next;
      r_core_data    <= w_core_data_next;
      r_done_cnt     <= w_done_cnt_next;
    end
  end

  assign c0_gnt_o       = r_gnt[0];
  assign c1_gnt_o       = r_gnt[1];
  assign c0_valid_o     = r_valid[0];
  assign c1_valid_o     = r_valid[1];
  assign c0_data_o      = g_client[0].r_cout;
  assign c1_data_o      = g_client[1].r_cout;
  assign core_request_o = r_core_request;
  assign core_data_o    = r_core_data;
  assign core_ack_o     = r_core_ack;
  assign busy_o         = r_busy;
  assign owner_o        = r_owner;
  assign done_cnt_o     = r_done_cnt;

endmodule

// File: tb/tb_kuznechik_arbiter.sv
// Bench for kuznechik_arbiter: instance 0 round-robin, instance 1 fixed priority.
// A transaction-level reference model predicts every output after every edge.
module tb_kuznechik_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn = 1'b1;

  logic [1:0][1:0]        req_d;
  logic [1:0][1:0]        ack_d;
  logic [1:0][1:0][127:0] din_d;
  logic [1:0]             cbusy_d;
  logic [1:0]             cvalid_d;
  logic [1:0][127:0]      cdin_d;

  wire  [1:0][1:0]        gnt_w;
  wire  [1:0][1:0]        val_w;
  wire  [1:0][1:0][127:0] dout_w;
  wire  [1:0]             creq_w;
  wire  [1:0]             cack_w;
  wire  [1:0]             busy_w;
  wire  [1:0]             owner_w;
  wire  [1:0][127:0]      cdout_w;
  wire  [1:0][15:0]       cnt_w;

  genvar gk;
  generate
    for (gk = 0; gk < 2; gk++) begin : g_dut
      kuznechik_arbiter #(.RR_EN(gk == 0 ? 1 : 0)) u_dut (
        .clk_i          (clk),
        .resetn_i       (resetn),
        .c0_req_i       (req_d[gk][0]),
        .c0_data_i      (din_d[gk][0]),
        .c0_gnt_o       (gnt_w[gk][0]),
        .c0_valid_o     (val_w[gk][0]),
        .c0_data_o      (dout_w[gk][0]),
        .c0_ack_i       (ack_d[gk][0]),
        .c1_req_i       (req_d[gk][1]),
        .c1_data_i      (din_d[gk][1]),
        .c1_gnt_o       (gnt_w[gk][1]),
        .c1_valid_o     (val_w[gk][1]),
        .c1_data_o      (dout_w[gk][1]),
        .c1_ack_i       (ack_d[gk][1]),
        .core_request_o (creq_w[gk]),
        .core_data_o    (cdout_w[gk]),
        .core_busy_i    (cbusy_d[gk]),
        .core_valid_i   (cvalid_d[gk]),
        .core_data_i    (cdin_d[gk]),
        .core_ack_o     (cack_w[gk]),
        .busy_o         (busy_w[gk]),
        .owner_o        (owner_w[gk]),
        .done_cnt_o     (cnt_w[gk])
      );
    end
  endgenerate

  localparam logic [127:0] PT = 128'h1122334455667700FFEEDDCCBBAA9988;
  localparam logic [127:0] CT = 128'h7F679D90BEBC24305A468D42B9D4EDCD;
  // {gnt1,gnt0,val1,val0,creq,cack,busy,owner,cnt,core_data,c0_data,c1_data}
  localparam logic [407:0] RST_VEC = {8'b0000_0001, 400'h0};

  int total = 0;
  int bad   = 0;

  // Reference model: one job record per instance
  bit           m_active [2];
  bit           m_gnow   [2];
  bit           m_res    [2];
  bit           m_acknow [2];
  int           m_owner  [2];
  logic [15:0]  m_cnt    [2];
  logic [127:0] m_core   [2];
  logic [127:0] m_out    [2][2];

  // Random driver knobs
  bit auto_en [2];
  int req_pct [2];
  int wd_pct  [2];
  int ack_pct [2];
  int busy_pct[2];
  int lat_max [2];
  int spur_pct[2];
  int pend    [2];

  int          glog0[$];
  int          glog1[$];
  logic [15:0] gcnt0[$];

  task automatic check(input string name, input logic [407:0] act, input logic [407:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_active[k] = 0;
      m_gnow[k]   = 0;
      m_res[k]    = 0;
      m_acknow[k] = 0;
      m_owner[k]  = 1;
      m_cnt[k]    = '0;
      m_core[k]   = '0;
      m_out[k][0] = '0;
      m_out[k][1] = '0;
    end
  endtask

  // One job at a time: grant it, wait for the core answer, wait for the client.
  task automatic model_step(input int k);
    int w;
    m_gnow[k]   = 0;
    m_acknow[k] = 0;
    if (!m_active[k]) begin
      if ((req_d[k][0] || req_d[k][1]) && !cbusy_d[k]) begin
        if (req_d[k][0] && req_d[k][1]) w = (k == 0) ? 1 - m_owner[k] : 0;
        else                            w = req_d[k][1] ? 1 : 0;
        m_owner[k]  = w;
        m_core[k]   = din_d[k][w];
        m_active[k] = 1;
        m_gnow[k]   = 1;
      end
    end else if (!m_res[k]) begin
      if (cvalid_d[k]) begin
        m_res[k]               = 1;
        m_out[k][m_owner[k]]   = cdin_d[k];
        m_acknow[k]            = 1;
      end
    end else if (ack_d[k][m_owner[k]]) begin
      m_active[k] = 0;
      m_res[k]    = 0;
      m_cnt[k]    = m_cnt[k] + 16'd1;
    end
  endtask

  function automatic logic [407:0] exp_vec(input int k);
    return {m_gnow[k] && m_owner[k] == 1, m_gnow[k] && m_owner[k] == 0,
            m_res[k] && m_owner[k] == 1,  m_res[k] && m_owner[k] == 0,
            m_gnow[k], m_acknow[k], m_active[k], m_owner[k] == 1,
            m_cnt[k], m_core[k], m_out[k][0], m_out[k][1]};
  endfunction

  function automatic logic [407:0] act_vec(input int k);
    return {gnt_w[k][1], gnt_w[k][0], val_w[k][1], val_w[k][0],
            creq_w[k], cack_w[k], busy_w[k], owner_w[k],
            cnt_w[k], cdout_w[k], dout_w[k][0], dout_w[k][1]};
  endfunction

  task automatic drive(input int k);
    for (int c = 0; c < 2; c++) begin
      if (req_d[k][c] && gnt_w[k][c]) begin
        req_d[k][c] = ($urandom_range(99) < req_pct[k]);
        if (req_d[k][c]) din_d[k][c] = rand128();
      end else if (req_d[k][c] && $urandom_range(99) < wd_pct[k]) begin
        req_d[k][c] = 1'b0;
      end else if (!req_d[k][c] && $urandom_range(99) < req_pct[k]) begin
        req_d[k][c] = 1'b1;
        din_d[k][c] = rand128();
      end
      ack_d[k][c] = ($urandom_range(99) < ack_pct[k]);
    end
    cvalid_d[k] = 1'b0;
    if (creq_w[k]) pend[k] = int'($urandom_range(lat_max[k]));
    if (pend[k] >= 0) begin
      if (pend[k] == 0) begin
        cvalid_d[k] = 1'b1;
        cdin_d[k]   = rand128();
      end
      pend[k]--;
    end else begin
      cvalid_d[k] = ($urandom_range(99) < spur_pct[k]);
      cdin_d[k]   = rand128();
    end
    cbusy_d[k] = ($urandom_range(99) < busy_pct[k]);
  endtask

  // One clock: model steps on the edge, outputs compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    if (resetn) begin
      for (int k = 0; k < 2; k++) model_step(k);
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("model%0d", k), act_vec(k), exp_vec(k));
      if (k == 0 && gnt_w[0][0]) begin glog0.push_back(0); gcnt0.push_back(cnt_w[0]); end
      if (k == 0 && gnt_w[0][1]) begin glog0.push_back(1); gcnt0.push_back(cnt_w[0]); end
      if (k == 1 && gnt_w[1][0]) glog1.push_back(0);
      if (k == 1 && gnt_w[1][1]) glog1.push_back(1);
      if (auto_en[k]) drive(k);
    end
  endtask

  // Entered and left on a falling edge.
  task automatic do_reset();
    resetn   = 1'b0;
    model_reset();
    req_d    = '0;
    ack_d    = '0;
    din_d    = '0;
    cbusy_d  = '0;
    cvalid_d = '0;
    cdin_d   = '0;
    pend[0]  = -1;
    pend[1]  = -1;
    #1;
    for (int k = 0; k < 2; k++) check($sformatf("reset%0d", k), act_vec(k), RST_VEC);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  typedef struct packed {
    bit        c0_req;
    bit        c0_ack;
    bit        c1_ack;
    bit        cvalid;
    bit [6:0]  exp;      // {gnt0,gnt1,val0,val1,creq,cack,busy}
    bit [15:0] exp_cnt;
  } vec_t;

  vec_t tbl [6];

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 7'b1000101, 16'd0};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 7'b0000001, 16'd0};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 7'b0010011, 16'd0};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 7'b0010001, 16'd0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 7'b0000000, 16'd1};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000, 16'd1};
    for (int k = 0; k < 2; k++) begin
      auto_en[k] = 0;
      pend[k]    = -1;
    end
    req_d = '0; ack_d = '0; din_d = '0; cbusy_d = '0; cvalid_d = '0; cdin_d = '0;

    @(negedge clk);
    do_reset();

    // Single block on the round-robin instance, table driven
    for (int r = 0; r < 6; r++) begin
      req_d[0][0]  = tbl[r].c0_req;
      din_d[0][0]  = PT;
      ack_d[0][0]  = tbl[r].c0_ack;
      ack_d[0][1]  = tbl[r].c1_ack;
      cvalid_d[0]  = tbl[r].cvalid;
      cdin_d[0]    = CT;
      tick();
      check($sformatf("single_row%0d", r),
            {gnt_w[0][0], gnt_w[0][1], val_w[0][0], val_w[0][1],
             creq_w[0], cack_w[0], busy_w[0], cnt_w[0]},
            {tbl[r].exp, tbl[r].exp_cnt});
      if (r == 0) check("single_core_data", cdout_w[0], PT);
      if (tbl[r].exp[4]) check($sformatf("single_c0_data%0d", r), dout_w[0][0], CT);
    end
    check("single_c0_data_retained", dout_w[0][0], CT);
    check("single_c1_silent", dout_w[0][1], 128'h0);

    // Continuous contention on both instances
    do_reset();
    glog0.delete(); glog1.delete(); gcnt0.delete();
    for (int k = 0; k < 2; k++) begin
      auto_en[k] = 1; req_pct[k] = 100; wd_pct[k] = 0; ack_pct[k] = 100;
      busy_pct[k] = 0; lat_max[k] = 3; spur_pct[k] = 0;
    end
    for (int n = 0; n < 400 && (glog0.size() < 5 || glog1.size() < 3); n++) tick();
    if (glog0.size() >= 5 && glog1.size() >= 3) begin
      check("rr_order", {glog0[0][0], glog0[1][0], glog0[2][0], glog0[3][0]}, 4'b0101);
      check("rr_done_cnt", gcnt0[4], 16'd4);
      check("fixed_order", {glog1[0][0], glog1[1][0], glog1[2][0]}, 3'b000);
    end else begin
      check("contention_timeout", 1'b1, 1'b0);
    end
    auto_en[0] = 0; auto_en[1] = 0;

    // Backpressure: c0 holds its result, c1 waits
    do_reset();
    req_d[0][0] = 1'b1; din_d[0][0] = PT;
    tick();
    check("bp_gnt0", gnt_w[0][0], 1'b1);
    req_d[0][0] = 1'b0; req_d[0][1] = 1'b1; din_d[0][1] = rand128();
    tick();
    cvalid_d[0] = 1'b1; cdin_d[0] = CT;
    tick();
    cvalid_d[0] = 1'b0; ack_d[0][1] = 1'b1;
    for (int n = 0; n < 20; n++) begin
      tick();
      check($sformatf("bp_hold%0d", n), {val_w[0][0], gnt_w[0][1], dout_w[0][0]}, {2'b10, CT});
    end
    ack_d[0][0] = 1'b1; ack_d[0][1] = 1'b0;
    tick();
    check("bp_release", {val_w[0][0], gnt_w[0][1]}, 2'b00);
    ack_d[0][0] = 1'b0;
    tick();
    check("bp_gnt1", gnt_w[0][1], 1'b1);

    // Core busy blocks the grant
    do_reset();
    cbusy_d[0] = 1'b1; req_d[0][1] = 1'b1; din_d[0][1] = rand128();
    for (int n = 0; n < 5; n++) begin
      tick();
      check($sformatf("busy_block%0d", n), {gnt_w[0][1], busy_w[0]}, 2'b00);
    end
    cbusy_d[0] = 1'b0;
    tick();
    check("busy_release_gnt", {gnt_w[0][1], busy_w[0]}, 2'b11);

    // Reset while waiting on the core
    do_reset();
    req_d[0][0] = 1'b1; din_d[0][0] = PT;
    tick();
    req_d[0][0] = 1'b0;
    tick();
    check("wait_reached", {busy_w[0], creq_w[0]}, 2'b10);
    resetn = 1'b0;
    model_reset();
    #1;
    check("reset_in_wait", act_vec(0), RST_VEC);
    @(negedge clk);
    resetn = 1'b1;
    cvalid_d[0] = 1'b1; cdin_d[0] = CT;
    tick();
    check("stale_result_ignored", {val_w[0][0], cack_w[0]}, 2'b00);
    cvalid_d[0] = 1'b0;
    tick();
    req_d[0][0] = 1'b1;
    tick();
    check("regrant_after_reset", gnt_w[0][0], 1'b1);

    // Random traffic against the model
    for (int e = 0; e < 6; e++) begin
      if (e % 2 == 0) do_reset();
      for (int k = 0; k < 2; k++) begin
        auto_en[k]  = 1;
        req_pct[k]  = int'($urandom_range(90, 20));
        wd_pct[k]   = int'($urandom_range(10));
        ack_pct[k]  = int'($urandom_range(90, 20));
        busy_pct[k] = int'($urandom_range(30));
        lat_max[k]  = int'($urandom_range(5));
        spur_pct[k] = int'($urandom_range(10));
      end
      repeat (500) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
